// File: rtl/fetch_decode_if.sv
// Handshake bundle between fetch, the fetch/decode queue and decode.
// The queue takes the slave view; the fetch/decode environment takes the master view.
interface fetch_decode_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned DEPTH        = 4
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                    flush;
    logic                    fetch_valid;
    logic                    fetch_ready;
    logic [ADDRESS_BITS-1:0] inst_PC_fetch;
    logic [DATA_WIDTH-1:0]   instruction_fetch;
    logic                    decode_ready;
    logic                    decode_valid;
    logic [ADDRESS_BITS-1:0] inst_PC_decode;
    logic [DATA_WIDTH-1:0]   instruction_decode;
    logic [OCC_W-1:0]        occupancy;

    modport master (
        output flush, fetch_valid, inst_PC_fetch, instruction_fetch, decode_ready,
        input  fetch_ready, decode_valid, inst_PC_decode, instruction_decode, occupancy
    );

    modport slave (
        input  flush, fetch_valid, inst_PC_fetch, instruction_fetch, decode_ready,
        output fetch_ready, decode_valid, inst_PC_decode, instruction_decode, occupancy
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// In-order {PC, instruction} queue between fetch and decode with synchronous flush.
// All decode-side outputs are registered; an empty queue presents PC 0 and a NOP bubble.
module fetch_decode_queue #(
    parameter int unsigned          DATA_WIDTH   = 32,
    parameter int unsigned          ADDRESS_BITS = 20,
    parameter int unsigned          DEPTH        = 4,
    parameter logic [DATA_WIDTH-1:0] NOP         = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic          clock,
    input  logic          reset,
    fetch_decode_if.slave q
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = ADDRESS_BITS + DATA_WIDTH;
    localparam logic [ENTRY_W-1:0] BUBBLE = {ADDRESS_BITS'(0), NOP};

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;
    logic               fetch_ready_q, fetch_ready_d;
    logic               decode_valid_q, decode_valid_d;
    logic [ENTRY_W-1:0] head_q, head_d;

    logic               push;
    logic               pop;
    logic               mem_we;
    logic [ENTRY_W-1:0] fetch_entry;

    assign fetch_entry = {q.inst_PC_fetch, q.instruction_fetch};
    assign push        = q.fetch_valid && fetch_ready_q;
    assign pop         = decode_valid_q && q.decode_ready;
    assign mem_we      = push && !q.flush;

    // Next-state; the head register is preloaded with whatever rd_ptr_d will point at,
    // taking the incoming entry directly when it lands in the slot decode sees next.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occupancy_d    = occupancy_q;
        fetch_ready_d  = 1'b1;
        decode_valid_d = 1'b0;
        head_d         = BUBBLE;

        if (q.flush) begin
            wr_ptr_d    = PTR_W'(0);
            rd_ptr_d    = PTR_W'(0);
            occupancy_d = OCC_W'(0);
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occupancy_d = occupancy_q + OCC_W'(push) - OCC_W'(pop);
        end

        fetch_ready_d  = (occupancy_d != OCC_W'(DEPTH));
        decode_valid_d = (occupancy_d != OCC_W'(0));

        if (decode_valid_d) begin
            if (mem_we && (wr_ptr_q == rd_ptr_d)) begin
                head_d = fetch_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= PTR_W'(0);
            rd_ptr_q       <= PTR_W'(0);
            occupancy_q    <= OCC_W'(0);
            fetch_ready_q  <= 1'b1;
            decode_valid_q <= 1'b0;
            head_q         <= BUBBLE;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occupancy_q    <= occupancy_d;
            fetch_ready_q  <= fetch_ready_d;
            decode_valid_q <= decode_valid_d;
            head_q         <= head_d;
        end
    end

    // Storage needs no reset: nothing is read from a slot before it is written.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[wr_ptr_q] <= fetch_entry;
    end

    assign q.fetch_ready        = fetch_ready_q;
    assign q.decode_valid       = decode_valid_q;
    assign q.occupancy          = occupancy_q;
    assign q.inst_PC_decode     = head_q[ENTRY_W-1 -: ADDRESS_BITS];
    assign q.instruction_decode = head_q[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue with a queue-based reference model of the
// expected decode-side contents.
module tb_fetch_decode_queue;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 20;
    localparam int unsigned DEPTH = 4;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [AW+DW-1:0] sb[$];

    fetch_decode_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH(DEPTH)) bus ();

    fetch_decode_queue #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clock (clock),
        .reset (reset),
        .q     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] pc);
        return {12'hC0D, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the reference queue.
    task automatic check_state(input string tag);
        logic [AW+DW-1:0] exp_head;
        exp_head = (sb.size() != 0) ? sb[0] : {AW'(0), NOP};
        chk({tag, ".occ"},   64'(bus.occupancy),    64'(sb.size()));
        chk({tag, ".dv"},    64'(bus.decode_valid), 64'(sb.size() != 0));
        chk({tag, ".fr"},    64'(bus.fetch_ready),  64'(sb.size() != DEPTH));
        chk({tag, ".head"},  64'({bus.inst_PC_decode, bus.instruction_decode}), 64'(exp_head));
    endtask

    // One clock: predict the handshake from the model, advance, then check.
    task automatic cycle(input string tag);
        bit               pu, po, fl;
        logic [AW+DW-1:0] entry;
        fl    = bus.flush;
        pu    = bus.fetch_valid && (sb.size() != DEPTH);
        po    = (sb.size() != 0) && bus.decode_ready;
        entry = {bus.inst_PC_fetch, bus.instruction_fetch};
        @(posedge clock);
        if (fl) begin
            sb.delete();
        end else begin
            if (po) void'(sb.pop_front());
            if (pu) sb.push_back(entry);
        end
        #1;
        check_state(tag);
    endtask

    task automatic drive(input bit fv, input logic [AW-1:0] pc, input bit dr, input bit fl,
                         input string tag);
        bus.fetch_valid       = fv;
        bus.inst_PC_fetch     = pc;
        bus.instruction_fetch = inst_of(pc);
        bus.decode_ready      = dr;
        bus.flush             = fl;
        cycle(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.flush             = 1'b0;
        bus.fetch_valid       = 1'b0;
        bus.inst_PC_fetch     = '0;
        bus.instruction_fetch = '0;
        bus.decode_ready      = 1'b0;

        // 1: reset held three cycles, then released between edges
        repeat (3) @(posedge clock);
        #1;
        check_state("rst_hold");
        reset = 1'b1;
        drive(1'b0, 20'h0, 1'b0, 1'b0, "rst_rel");

        // 2: fill with decode stalled, then a fifth push is refused
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(i * 4), 1'b0, 1'b0, "fill");
        chk("full_occ", 64'(bus.occupancy), 64'(4));
        drive(1'b1, 20'h10, 1'b0, 1'b0, "full_refuse");
        chk("full_head_pc", 64'(bus.inst_PC_decode), 64'(0));

        // 3: pop while full takes no push; 0x10 goes in the next cycle
        drive(1'b1, 20'h10, 1'b1, 1'b0, "full_pop");
        chk("full_pop_occ", 64'(bus.occupancy), 64'(3));
        drive(1'b1, 20'h10, 1'b0, 1'b0, "push_after_pop");
        for (int i = 0; i < 5; i++) drive(1'b0, 20'h0, 1'b1, 1'b0, "drain");
        chk("drained_empty", 64'(bus.decode_valid), 64'(0));

        // 4: streaming, ten items, pointers wrap twice
        for (int i = 0; i < 10; i++) drive(1'b1, AW'(i * 4), 1'b1, 1'b0, "stream");
        drive(1'b0, 20'h0, 1'b1, 1'b0, "stream_tail");
        chk("stream_end_nop", 64'(bus.instruction_decode), 64'(NOP));

        // 5: flush beats a simultaneous push and pop
        for (int i = 0; i < 3; i++) drive(1'b1, AW'(32'h100 + i * 4), 1'b0, 1'b0, "pre_flush");
        drive(1'b1, 20'h200, 1'b1, 1'b1, "flush");
        chk("flush_occ", 64'(bus.occupancy), 64'(0));
        drive(1'b1, 20'h300, 1'b0, 1'b0, "post_flush_push");
        chk("post_flush_pc", 64'(bus.inst_PC_decode), 64'(20'h300));
        drive(1'b0, 20'h0, 1'b1, 1'b0, "post_flush_drain");

        // 6: asynchronous reset mid-cycle with two entries queued
        drive(1'b1, 20'h400, 1'b0, 1'b0, "pre_rst");
        drive(1'b1, 20'h404, 1'b0, 1'b0, "pre_rst");
        bus.fetch_valid = 1'b0;
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check_state("async_rst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1'b0, 20'h0, 1'b1, 1'b0, "rst_release");
        drive(1'b1, 20'h500, 1'b0, 1'b0, "after_rst_push");
        drive(1'b0, 20'h0, 1'b1, 1'b0, "after_rst_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
